// File: rtl/spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// spi_frame_ctrl
//
// Receives a frame of pixel bits over a raw (asynchronous) SPI link into a
// double-buffered frame store and hands the finished bank to the VGA reader
// at the next frame boundary.
//
// The SPI clock and chip select are synchronised into CLK_40. A bit is
// accepted on each synchronised SPI_clk rising edge while receiving with chip
// select low. After FRAME_BITS accepted bits, the frame is complete. The
// controller then waits in FULL until frame_start, and swaps the displayed
// bank at that point.
//
// Parameters
//   FRAME_BITS   pixel bits per frame (default 30000 = 200x150)
//   SYNC_STAGES  synchroniser depth for SPI_clk and chip_select (>= 2)
//
// Ports
//   CLK_40            in   40 MHz system clock, rising edge
//   reset             in   synchronous, active-high reset
//   SPI_clk           in   raw SPI clock (asynchronous)
//   chip_select       in   raw SPI chip select, active-low (asynchronous)
//   frame_start       in   one-cycle pulse at VGA vertical-blank start
//   SPI_clk_en        out  one-cycle strobe per accepted SPI bit
//   video_data_ready  out  high while a frame is being written
//   read_bank1        out  bank 1 is being displayed
//   read_bank2        out  bank 2 is being displayed
//   frame_done        out  one-cycle pulse when a frame's last bit is accepted
//   overrun           out  sticky: new frame started before previous swap
//
// Optional feature
//   SPI_OVERRUN_DETECT_EN  when defined, a synchronised chip_select falling
//                          edge while FULL sets the sticky overrun flag.
//                          When undefined, overrun is tied low.
// -----------------------------------------------------------------------------
module spi_frame_ctrl #(
    parameter int FRAME_BITS  = 30000,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_40,
    input  logic reset,
    input  logic SPI_clk,
    input  logic chip_select,
    input  logic frame_start,
    output logic SPI_clk_en,
    output logic video_data_ready,
    output logic read_bank1,
    output logic read_bank2,
    output logic frame_done,
    output logic overrun
);

    localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic                   sclk_prev_r;
    logic                   spi_clk_en_r;
    logic                   video_data_ready_r;
    logic                   read_bank1_r;
    logic                   read_bank2_r;
    logic                   write_bank2_r;   // 0: next frame goes to bank 1
    logic                   frame_done_r;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   sclk_rise_s;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;

    // Synchronisers for the raw SPI inputs plus the SPI clock edge-detect flop.
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SPI_clk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], chip_select};
            sclk_prev_r <= sclk_s;
        end
    end

    // Frame FSM: bit counting, completion, abort and bank swap, registered outputs.
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            cnt_r              <= {CNT_W{1'b0}};
            spi_clk_en_r       <= 1'b0;
            video_data_ready_r <= 1'b0;
            read_bank1_r       <= 1'b0;
            read_bank2_r       <= 1'b0;
            write_bank2_r      <= 1'b0;
            frame_done_r       <= 1'b0;
        end else begin
            spi_clk_en_r <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (!cs_s) begin
                        state_r            <= ST_RECEIVE;
                        video_data_ready_r <= 1'b1;
                    end
                end
                ST_RECEIVE: begin
                    if (cs_s) begin
                        // Master released chip select early: drop the partial frame.
                        state_r            <= ST_IDLE;
                        cnt_r              <= {CNT_W{1'b0}};
                        video_data_ready_r <= 1'b0;
                    end else if (sclk_rise_s) begin
                        spi_clk_en_r <= 1'b1;
                        if (cnt_r == LAST_CNT) begin
                            state_r            <= ST_FULL;
                            cnt_r              <= {CNT_W{1'b0}};
                            frame_done_r       <= 1'b1;
                            video_data_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    // frame_done_r is still high in the first FULL cycle, so a
                    // frame_start coinciding with the completion is ignored.
                    if (frame_start && !frame_done_r) begin
                        state_r       <= ST_IDLE;
                        read_bank1_r  <= ~write_bank2_r;
                        read_bank2_r  <= write_bank2_r;
                        write_bank2_r <= ~write_bank2_r;
                    end
                end
                default: begin
                    state_r            <= ST_IDLE;
                    cnt_r              <= {CNT_W{1'b0}};
                    video_data_ready_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_OVERRUN_DETECT_EN
    logic cs_prev_r;
    logic overrun_r;

    // Sticky overrun: the master opened a new frame while the last one awaits swap.
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            cs_prev_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            cs_prev_r <= cs_s;
            if ((state_r == ST_FULL) && cs_prev_r && !cs_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

    assign SPI_clk_en       = spi_clk_en_r;
    assign video_data_ready = video_data_ready_r;
    assign read_bank1       = read_bank1_r;
    assign read_bank2       = read_bank2_r;
    assign frame_done       = frame_done_r;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_ctrl
//
// Self-checking bench for spi_frame_ctrl with FRAME_BITS = 8.
// Every SPI bit that should be accepted pushes an expected record (bit index,
// frame_done expectation) into a scoreboard queue. A negedge monitor pops one
// record per SPI_clk_en strobe. The main sequence is a table of frame/swap
// steps with the expected display state, followed by hand-written corner cases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_frame_ctrl;

    localparam int FB = 8;

    logic clk;
    logic reset;
    logic spi_clk;
    logic chip_select;
    logic frame_start;
    logic spi_clk_en;
    logic video_data_ready;
    logic read_bank1;
    logic read_bank2;
    logic frame_done;
    logic overrun;

    int n_checks;
    int n_fail;
    int frames_seen;

    typedef struct {
        int idx;
        bit fd;
    } exp_bit_t;

    exp_bit_t sb_q[$];

    typedef struct {
        bit do_fstart;   // 1: pulse frame_start, 0: send nbits
        int nbits;
        bit exp_rb1;
        bit exp_rb2;
        int exp_frames;
    } step_t;

    step_t steps [7];

    bit exp_ovr;

    spi_frame_ctrl #(
        .FRAME_BITS (FB),
        .SYNC_STAGES(2)
    ) dut (
        .CLK_40          (clk),
        .reset           (reset),
        .SPI_clk         (spi_clk),
        .chip_select     (chip_select),
        .frame_start     (frame_start),
        .SPI_clk_en      (spi_clk_en),
        .video_data_ready(video_data_ready),
        .read_bank1      (read_bank1),
        .read_bank2      (read_bank2),
        .frame_done      (frame_done),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each strobe must match the oldest expected bit.
    always @(negedge clk) begin
        if (spi_clk_en) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_strobe: got SPI_clk_en=1 expected no strobe (t=%0t)", $time);
            end else begin
                exp_bit_t e;
                e = sb_q.pop_front();
                if (frame_done != e.fd) begin
                    n_fail++;
                    $display("FAIL sb_frame_done bit %0d: got %0b expected %0b (t=%0t)",
                             e.idx, frame_done, e.fd, $time);
                end
            end
        end else if (frame_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL fd_without_strobe: got frame_done=1 expected 0 (t=%0t)", $time);
        end
        if (frame_done) frames_seen++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_fstart();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_cycles(2);
    endtask

    // Drive one SPI bit; optionally fire frame_start alongside its strobe.
    task automatic send_bit(input int idx, input bit fd, input bit expect_acc, input bit fs_on_strobe);
        bit seen;
        if (expect_acc) begin
            exp_bit_t e;
            e.idx = idx;
            e.fd  = fd;
            sb_q.push_back(e);
        end
        spi_clk = 1'b1;
        if (fs_on_strobe) begin
            seen = 1'b0;
            for (int k = 0; k < 12 && !seen; k++) begin
                @(negedge clk);
                if (spi_clk_en) seen = 1'b1;
            end
            check("last_bit_strobe_seen", int'(seen), 1);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            wait_cycles(2);
        end else begin
            wait_cycles(4);
        end
        spi_clk = 1'b0;
        wait_cycles(4);
    endtask

    task automatic send_frame(input int nbits, input bit fs_on_last);
        chip_select = 1'b0;
        wait_cycles(6);
        for (int i = 0; i < nbits; i++) begin
            send_bit(i, (i == FB - 1), 1'b1, fs_on_last && (i == nbits - 1));
        end
        chip_select = 1'b1;
        wait_cycles(6);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_SPI_clk_en"}, int'(spi_clk_en), 0);
        check({tag, "_video_data_ready"}, int'(video_data_ready), 0);
        check({tag, "_read_bank1"}, int'(read_bank1), 0);
        check({tag, "_read_bank2"}, int'(read_bank2), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        frames_seen = 0;
        reset       = 1'b1;
        spi_clk     = 1'b0;
        chip_select = 1'b1;
        frame_start = 1'b0;
`ifdef SPI_OVERRUN_DETECT_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif

        // {do_fstart, nbits, exp_rb1, exp_rb2, exp_frames}
        steps[0] = '{1'b0, 8, 1'b0, 1'b0, 1};   // first frame -> FULL, nothing shown
        steps[1] = '{1'b1, 0, 1'b1, 1'b0, 1};   // swap: bank 1 displayed
        steps[2] = '{1'b0, 8, 1'b1, 1'b0, 2};   // second frame into bank 2
        steps[3] = '{1'b1, 0, 1'b0, 1'b1, 2};   // swap: bank 2 displayed
        steps[4] = '{1'b0, 5, 1'b0, 1'b1, 2};   // aborted frame, display unchanged
        steps[5] = '{1'b0, 8, 1'b0, 1'b1, 3};   // full frame after abort
        steps[6] = '{1'b1, 0, 1'b1, 1'b0, 3};   // swap back to bank 1

        wait_cycles(4);
        check_all_zero("reset");
        reset = 1'b0;
        wait_cycles(8);
        check_all_zero("post_reset_idle");

        for (int s = 0; s < 7; s++) begin
            if (steps[s].do_fstart) begin
                pulse_fstart();
            end else begin
                send_frame(steps[s].nbits, 1'b0);
            end
            check($sformatf("step%0d_read_bank1", s), int'(read_bank1), int'(steps[s].exp_rb1));
            check($sformatf("step%0d_read_bank2", s), int'(read_bank2), int'(steps[s].exp_rb2));
            check($sformatf("step%0d_vdr", s), int'(video_data_ready), 0);
            check($sformatf("step%0d_frames", s), frames_seen, steps[s].exp_frames);
            check($sformatf("step%0d_sb_drain", s), sb_q.size(), 0);
        end

        // frame_start coincident with the final bit's strobe must not swap.
        send_frame(FB, 1'b1);
        check("coincident_fs_read_bank1", int'(read_bank1), 1);
        check("coincident_fs_read_bank2", int'(read_bank2), 0);
        check("coincident_fs_frames", frames_seen, 4);
        pulse_fstart();
        check("late_fs_read_bank1", int'(read_bank1), 0);
        check("late_fs_read_bank2", int'(read_bank2), 1);

        // New frame opened while FULL: no strobes, overrun per build option.
        send_frame(FB, 1'b0);
        check("full_frames", frames_seen, 5);
        chip_select = 1'b0;
        wait_cycles(6);
        for (int i = 0; i < 3; i++) begin
            send_bit(i, 1'b0, 1'b0, 1'b0);
        end
        check("overrun_flag", int'(overrun), int'(exp_ovr));
        check("overrun_no_vdr", int'(video_data_ready), 0);
        chip_select = 1'b1;
        wait_cycles(6);
        pulse_fstart();
        check("after_overrun_read_bank1", int'(read_bank1), 1);
        check("after_overrun_read_bank2", int'(read_bank2), 0);
        check("overrun_sticky", int'(overrun), int'(exp_ovr));

        // Reset in the middle of a frame discards it and restarts at bank 1.
        chip_select = 1'b0;
        wait_cycles(6);
        for (int i = 0; i < 4; i++) begin
            send_bit(i, 1'b0, 1'b1, 1'b0);
        end
        check("midreset_sb_drain", sb_q.size(), 0);
        @(negedge clk);
        reset       = 1'b1;
        chip_select = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(8);
        send_frame(FB, 1'b0);
        check("midreset_frames", frames_seen, 6);
        check("midreset_prefs_read_bank1", int'(read_bank1), 0);
        check("midreset_prefs_read_bank2", int'(read_bank2), 0);
        pulse_fstart();
        check("midreset_read_bank1", int'(read_bank1), 1);
        check("midreset_read_bank2", int'(read_bank2), 0);
        check("final_sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected completion before limit");
        $fatal(1, "timeout");
    end

endmodule
